// File: rtl/calc_all_distances_gen.sv
// Point-to-centroid distance engine over a shared single-port BRAM (Manhattan or squared Euclidean).
// Define CALC_DIST_LABEL_EN to add nearest-centroid tracking and per-point label writes.
module calc_all_distances_gen #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 14,
  parameter int MAX_DIMS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              ready,
  input  logic              mode,
  input  logic [ADDR_W-1:0] num_vals,
  input  logic [ADDR_W-1:0] num_clusters,
  input  logic [ADDR_W-1:0] num_dims,
  input  logic [ADDR_W-1:0] pts_base,
  input  logic [ADDR_W-1:0] cent_base,
  input  logic [ADDR_W-1:0] dist_base,
  input  logic [ADDR_W-1:0] label_base,
  output logic [ADDR_W-1:0] PNL_BRAM_addr,
  output logic [DATA_W-1:0] PNL_BRAM_din,
  input  logic [DATA_W-1:0] PNL_BRAM_dout,
  output logic              PNL_BRAM_we,
  output logic              sat_flag
);

  localparam int ACC_W = 2*DATA_W + $clog2(MAX_DIMS) + 1;
  localparam int SQ_W  = 2*DATA_W + 2;

  typedef enum logic [2:0] {IDLE, ZERO, RD_PT, RD_CT, ACC, WR_DIST, WR_LABEL} state_t;

  state_t state_q, state_d;
  logic              mode_q, mode_d, sat_flag_q, sat_flag_d;
  logic [ADDR_W-1:0] nv_q, nv_d, nc_q, nc_d, nd_q, nd_d;
  logic [ADDR_W-1:0] p_q, p_d, c_q, c_d, d_q, d_d;
  logic [ADDR_W-1:0] pt_row_q, pt_row_d, pt_addr_q, pt_addr_d;
  logic [ADDR_W-1:0] ct_addr_q, ct_addr_d, cent_base_q, cent_base_d, dist_addr_q, dist_addr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
`ifdef CALC_DIST_LABEL_EN
  logic [ADDR_W-1:0] label_addr_q, label_addr_d, label_q, label_d;
  logic [ACC_W-1:0]  min_q, min_d;
`else
  logic unused_label_base;
  assign unused_label_base = ^label_base;
`endif

  logic signed [DATA_W:0] diff;
  logic signed [SQ_W-1:0] diff_x, sq;
  logic [DATA_W:0]        abs_diff;
  logic [ACC_W-1:0]       term;
  logic                   sat;

  // Operands are sign-extended by one bit so a-b can never wrap.
  always_comb begin
    diff     = $signed({a_q[DATA_W-1], a_q}) - $signed({PNL_BRAM_dout[DATA_W-1], PNL_BRAM_dout});
    abs_diff = diff[DATA_W] ? $unsigned(-diff) : $unsigned(diff);
    diff_x   = SQ_W'(diff);
    sq       = diff_x * diff_x;
    term     = mode_q ? ACC_W'($unsigned(sq)) : ACC_W'(abs_diff);
    sat      = |acc_q[ACC_W-1:DATA_W];
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    sat_flag_d  = sat_flag_q;
    nv_d        = nv_q;
    nc_d        = nc_q;
    nd_d        = nd_q;
    p_d         = p_q;
    c_d         = c_q;
    d_d         = d_q;
    pt_row_d    = pt_row_q;
    pt_addr_d   = pt_addr_q;
    ct_addr_d   = ct_addr_q;
    cent_base_d = cent_base_q;
    dist_addr_d = dist_addr_q;
    a_d         = a_q;
    acc_d       = acc_q;
`ifdef CALC_DIST_LABEL_EN
    label_addr_d = label_addr_q;
    label_d      = label_q;
    min_d        = min_q;
`endif
    PNL_BRAM_addr = '0;
    PNL_BRAM_din  = '0;
    PNL_BRAM_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d      = mode;
          nv_d        = num_vals;
          nc_d        = num_clusters;
          nd_d        = num_dims;
          p_d         = '0;
          c_d         = '0;
          d_d         = '0;
          pt_row_d    = pts_base;
          pt_addr_d   = pts_base;
          ct_addr_d   = cent_base;
          cent_base_d = cent_base;
          dist_addr_d = dist_base;
          acc_d       = '0;
          sat_flag_d  = 1'b0;
`ifdef CALC_DIST_LABEL_EN
          label_addr_d = label_base;
          label_d      = '0;
          min_d        = '1;
`endif
          if (num_vals == '0 || num_clusters == '0 || num_dims == '0) state_d = ZERO;
          else                                                          state_d = RD_PT;
        end
      end
      ZERO: state_d = IDLE;
      RD_PT: begin
        PNL_BRAM_addr = pt_addr_q;
        state_d       = RD_CT;
      end
      RD_CT: begin
        PNL_BRAM_addr = ct_addr_q;
        a_d           = PNL_BRAM_dout;
        pt_addr_d     = pt_addr_q + ADDR_W'(1);
        ct_addr_d     = ct_addr_q + ADDR_W'(1);
        state_d       = ACC;
      end
      ACC: begin
        acc_d = acc_q + term;
        if (d_q == nd_q - ADDR_W'(1)) begin
          d_d     = '0;
          state_d = WR_DIST;
        end else begin
          d_d     = d_q + ADDR_W'(1);
          state_d = RD_PT;
        end
      end
      WR_DIST: begin
        PNL_BRAM_addr = dist_addr_q;
        PNL_BRAM_din  = sat ? '1 : acc_q[DATA_W-1:0];
        PNL_BRAM_we   = 1'b1;
        if (sat) sat_flag_d = 1'b1;
        dist_addr_d = dist_addr_q + ADDR_W'(1);
        acc_d       = '0;
`ifdef CALC_DIST_LABEL_EN
        if (acc_q < min_q) begin
          min_d   = acc_q;
          label_d = c_q;
        end
`endif
        if (c_q == nc_q - ADDR_W'(1)) begin
          // pt_addr_q already points at the next point's first element here.
          c_d       = '0;
          ct_addr_d = cent_base_q;
          pt_row_d  = pt_addr_q;
`ifdef CALC_DIST_LABEL_EN
          state_d   = WR_LABEL;
`else
          if (p_q == nv_q - ADDR_W'(1)) begin
            state_d = IDLE;
          end else begin
            p_d     = p_q + ADDR_W'(1);
            state_d = RD_PT;
          end
`endif
        end else begin
          c_d       = c_q + ADDR_W'(1);
          pt_addr_d = pt_row_q;
          state_d   = RD_PT;
        end
      end
`ifdef CALC_DIST_LABEL_EN
      WR_LABEL: begin
        PNL_BRAM_addr = label_addr_q;
        PNL_BRAM_din  = DATA_W'(label_q);
        PNL_BRAM_we   = 1'b1;
        label_addr_d  = label_addr_q + ADDR_W'(1);
        label_d       = '0;
        min_d         = '1;
        if (p_q == nv_q - ADDR_W'(1)) begin
          state_d = IDLE;
        end else begin
          p_d     = p_q + ADDR_W'(1);
          state_d = RD_PT;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= 1'b0;
      sat_flag_q  <= 1'b0;
      nv_q        <= '0;
      nc_q        <= '0;
      nd_q        <= '0;
      p_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      pt_row_q    <= '0;
      pt_addr_q   <= '0;
      ct_addr_q   <= '0;
      cent_base_q <= '0;
      dist_addr_q <= '0;
      a_q         <= '0;
      acc_q       <= '0;
`ifdef CALC_DIST_LABEL_EN
      label_addr_q <= '0;
      label_q      <= '0;
      min_q        <= '1;
`endif
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      sat_flag_q  <= sat_flag_d;
      nv_q        <= nv_d;
      nc_q        <= nc_d;
      nd_q        <= nd_d;
      p_q         <= p_d;
      c_q         <= c_d;
      d_q         <= d_d;
      pt_row_q    <= pt_row_d;
      pt_addr_q   <= pt_addr_d;
      ct_addr_q   <= ct_addr_d;
      cent_base_q <= cent_base_d;
      dist_addr_q <= dist_addr_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
`ifdef CALC_DIST_LABEL_EN
      label_addr_q <= label_addr_d;
      label_q      <= label_d;
      min_q        <= min_d;
`endif
    end
  end

  assign ready    = (state_q == IDLE);
  assign sat_flag = sat_flag_q;

endmodule

// File: doc/calc_all_distances_gen.md
# calc_all_distances_gen

Parametrised successor to the cluster distance engine. On `start`, it walks every point against every centroid held in the PNL BRAM and accumulates a per-dimension distance in one of two selectable metrics. It writes each point-to-centroid distance back to BRAM, and optionally writes the nearest-centroid label per point. It sits between the LPD controller FSM and the shared PNL BRAM port, replacing the external single-distance sub-block handshake with an internal accumulator.

## Interface
- `DATA_W`, 16: BRAM data width; operands are signed two's complement.
- `ADDR_W`, 14: BRAM address width.
- `MAX_DIMS`, 8: largest supported `num_dims`; sizes the accumulator.
- Accumulator width `ACC_W` = 2*DATA_W+$clog2(MAX_DIMS)+1 (derived).

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse; accepted only when `ready`=1.
- `ready` out 1: 1 = idle; 0 while a run is in progress.
- `mode` in 1: 0 = Manhattan (sum |a-b|); 1 = squared Euclidean (sum (a-b)^2). Sampled at start.
- `num_vals` in ADDR_W: number of points. Sampled at start.
- `num_clusters` in ADDR_W: number of centroids. Sampled at start.
- `num_dims` in ADDR_W: number of dimensions, 0..MAX_DIMS. Sampled at start.
- `pts_base` in ADDR_W: base address of the points array, point-major.
- `cent_base` in ADDR_W: base address of the centroids array, centroid-major.
- `dist_base` in ADDR_W: base address of the distance output.
- `label_base` in ADDR_W: base address of the label output.
- `PNL_BRAM_addr` out ADDR_W: BRAM address.
- `PNL_BRAM_din` out DATA_W: BRAM write data.
- `PNL_BRAM_dout` in DATA_W: BRAM read data, valid one cycle after the address.
- `PNL_BRAM_we` out 1: BRAM write enable.
- `sat_flag` out 1: sticky; set when any written distance saturated. Cleared at start.

## Operation
- Element addressing:
  - Point element: pts_base + p*num_dims + d.
  - Centroid element: cent_base + c*num_dims + d.
  - Distance: dist_base + p*num_clusters + c.
  - Label: label_base + p.
- All addresses are produced by running incrementers, with no multipliers. Address arithmetic wraps modulo 2^ADDR_W.
- FSM states: IDLE → RD_PT → RD_CT → ACC → (next d: RD_PT | last d: WR_DIST) → (next c: RD_PT | last c: WR_LABEL) → (next p: RD_PT | last p: IDLE).
- RD_PT: drive the point address.
- RD_CT: drive the centroid address and capture the point `dout`.
- ACC: capture the centroid `dout`. Compute diff = a-b at DATA_W+1 bits signed, then add |diff| or diff*diff to the accumulator. The accumulator never overflows.
- WR_DIST:
  - we=1, din = accumulator saturated to unsigned DATA_W (all-ones on overflow; overflow sets `sat_flag`).
  - Compare the unsaturated accumulator against the running minimum. A strictly-less result updates min and label, so ties keep the lowest index.
  - Clear the accumulator.
- WR_LABEL: we=1, din = label, zero-extended. Reset min to all-ones for the next point.
- If num_vals, num_clusters or num_dims is 0: go IDLE → one bookkeeping cycle → IDLE, with no BRAM writes.
- `start` while `ready`=0 is ignored.
- `start` and configuration inputs may change freely mid-run, since they are latched.

## Timing
- Reset values: `ready`=1, `PNL_BRAM_we`=0, `PNL_BRAM_addr`=0, `PNL_BRAM_din`=0, `sat_flag`=0, FSM=IDLE.
- `ready` falls on the cycle after `start` is accepted and rises on the cycle after the final write.
- `PNL_BRAM_we` is high for exactly one cycle per write. It is never high during read states.
- Run length from start to ready=1 is num_vals*(num_clusters*(3*num_dims+1)+1)+1 cycles. The degenerate zero-size case takes 2 cycles.
- Reset asserted mid-run: all outputs return to their reset values immediately (asynchronous) and no further writes occur. Partial results in BRAM are undefined.

## Configuration
- `CALC_DIST_LABEL_EN` defined: min tracking and the WR_LABEL state are present, and labels are written.
- Not defined: WR_LABEL, the min comparator and the label register are removed. `label_base` is unused, and WR_DIST of the last cluster goes straight to the next point or IDLE. Run length becomes num_vals*num_clusters*(3*num_dims+1)+1.

## Test plan
- Manhattan, num_vals=1, num_clusters=2, num_dims=2, point (3,4), centroids (0,0) and (3,5) → writes 7 and 1, label 1; ready returns after 16 cycles.
- Same data, mode=1 → writes 25 and 1, label 1; `sat_flag`=0.
- DATA_W=16, point (-32768,-32768), centroid (32767,32767), mode=1 → distance 0xFFFF, `sat_flag`=1; the next start clears the flag.
- Two identical centroids (5,5), point (1,1) → both distances 8 (Manhattan), label 0 (tie goes to the lowest index).
- num_dims=0 → no `we` pulses; ready=0 for exactly 1 cycle; a second start during a busy run is ignored.
- Reset pulled low mid-run (e.g. cycle 6) → `we`=0 and ready=1 in the same cycle; a fresh start then completes with correct results.
